// File: rtl/nexys4_disp_pkg.sv
// Shared constants for the Nexys4 seven-segment display path.
// Glyph codes above 0x0F select non-hex symbols; all segment/anode values are active-low.
package nexys4_disp_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [4:0] glyph_code_t;

    localparam glyph_code_t GLYPH_BLANK = 5'h10;
    localparam glyph_code_t GLYPH_MINUS = 5'h11;
    localparam glyph_code_t GLYPH_UNDER = 5'h12;
    localparam glyph_code_t GLYPH_DEG   = 5'h13;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 5-bit glyph code to active-low segment pattern, ordered {g,f,e,d,c,b,a}.
// Codes 0x00-0x0F are hex digits (lowercase b and d); unassigned codes are blank.
module seg_glyph_decode
    import nexys4_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'h00:       seg = 7'h40;
            5'h01:       seg = 7'h79;
            5'h02:       seg = 7'h24;
            5'h03:       seg = 7'h30;
            5'h04:       seg = 7'h19;
            5'h05:       seg = 7'h12;
            5'h06:       seg = 7'h02;
            5'h07:       seg = 7'h78;
            5'h08:       seg = 7'h00;
            5'h09:       seg = 7'h10;
            5'h0A:       seg = 7'h08;
            5'h0B:       seg = 7'h03;
            5'h0C:       seg = 7'h46;
            5'h0D:       seg = 7'h21;
            5'h0E:       seg = 7'h06;
            5'h0F:       seg = 7'h0E;
            GLYPH_MINUS: seg = 7'h3F;
            GLYPH_UNDER: seg = 7'h77;
            GLYPH_DEG:   seg = 7'h1C;
            default:     seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Eight-digit time-multiplexed seven-segment driver with once-per-frame shadow capture
// of the digit/dp registers and a one-cycle frame_tick after each frame wrap.
module sevenseg_scan
    import nexys4_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic [7:0] dig0,
    input  logic [7:0] dig1,
    input  logic [7:0] dig2,
    input  logic [7:0] dig3,
    input  logic [7:0] dig4,
    input  logic [7:0] dig5,
    input  logic [7:0] dig6,
    input  logic [7:0] dig7,
    input  logic [7:0] dp_lo,
    input  logic [7:0] dp_hi,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W:0]    BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        idx_reg, idx_next;
    glyph_code_t       shadow_dig_reg [NUM_DIGITS];
    logic [7:0]        shadow_dp_reg;
    logic [7:0]        an_reg;
    logic [6:0]        seg_reg;
    logic              dp_reg;
    logic              tick_reg;

    glyph_code_t       dig_in [NUM_DIGITS];
    logic [7:0]        dp_in;
    logic              last_slot;
    logic              wrap;
    logic              blanking;
    logic [6:0]        sel_seg;
    logic              unused_hi_bits;

    assign dig_in[0] = dig0[4:0];
    assign dig_in[1] = dig1[4:0];
    assign dig_in[2] = dig2[4:0];
    assign dig_in[3] = dig3[4:0];
    assign dig_in[4] = dig4[4:0];
    assign dig_in[5] = dig5[4:0];
    assign dig_in[6] = dig6[4:0];
    assign dig_in[7] = dig7[4:0];
    assign dp_in     = {dp_hi[3:0], dp_lo[3:0]};

    assign unused_hi_bits = ^{dig0[7:5], dig1[7:5], dig2[7:5], dig3[7:5],
                              dig4[7:5], dig5[7:5], dig6[7:5], dig7[7:5],
                              dp_lo[7:4], dp_hi[7:4]};

    always_comb begin
        last_slot = (cnt_reg == CNT_LAST);
        wrap      = last_slot && (idx_reg == 3'd7);
        cnt_next  = last_slot ? '0 : cnt_reg + 1'b1;
        idx_next  = last_slot ? idx_reg + 3'd1 : idx_reg;
        blanking  = ({1'b0, cnt_reg} < BLANK_END);
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
        end
    end

    // Shadow copy changes only at the frame wrap so firmware updates never tear mid-frame.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_dig_reg[i] <= GLYPH_BLANK;
            end
            shadow_dp_reg <= '0;
        end else if (wrap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_dig_reg[i] <= dig_in[i];
            end
            shadow_dp_reg <= dp_in;
        end
    end

    seg_glyph_decode u_glyph (
        .code (shadow_dig_reg[idx_reg]),
        .seg  (sel_seg)
    );

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            an_reg   <= AN_OFF;
            seg_reg  <= SEG_OFF;
            dp_reg   <= 1'b1;
            tick_reg <= 1'b0;
        end else begin
            an_reg   <= blanking ? AN_OFF  : ~(8'd1 << idx_reg);
            seg_reg  <= blanking ? SEG_OFF : sel_seg;
            dp_reg   <= blanking ? 1'b1    : ~shadow_dp_reg[idx_reg];
            tick_reg <= wrap;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = tick_reg;

endmodule
